// File: rtl/mod_addsub_ctrl_pkg.sv
// Shared definitions for the modular add/sub controller: state encoding,
// default operand width and adder op codes.
package mod_addsub_ctrl_pkg;

   localparam int WIDTH_DEF = 1027;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ISSUE1 = 3'd1;
   localparam logic [2:0] ST_WAIT1  = 3'd2;
   localparam logic [2:0] ST_ISSUE2 = 3'd3;
   localparam logic [2:0] ST_WAIT2  = 3'd4;
   localparam logic [2:0] ST_FINISH = 3'd5;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      ISSUE1 = ST_ISSUE1,
      WAIT1  = ST_WAIT1,
      ISSUE2 = ST_ISSUE2,
      WAIT2  = ST_WAIT2,
      FINISH = ST_FINISH
   } state_t;

   localparam logic MP_ADD = 1'b0;
   localparam logic MP_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Modular add/sub controller: drives an external mp adder through exactly two
// operations (raw op, then -M/+M correction) so timing never depends on data.
module mod_addsub_ctrl
   import mod_addsub_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             subtract,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             add_start,
   output logic             add_subtract,
   output logic             add_carry_in,
   output logic [WIDTH-1:0] add_in_a,
   output logic [WIDTH-1:0] add_in_b,
   input  logic [WIDTH:0]   add_result,
   input  logic             add_done
);

   state_t           state;
   logic [WIDTH-1:0] a_lat;
   logic [WIDTH-1:0] b_lat;
   logic [WIDTH-1:0] m_lat;
   logic             sub_lat;
   logic [WIDTH-1:0] s_reg;
   logic             flag;

   // The adder derives the +1 of two's-complement subtraction internally.
   assign add_carry_in = 1'b0;

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         a_lat        <= '0;
         b_lat        <= '0;
         m_lat        <= '0;
         sub_lat      <= 1'b0;
         s_reg        <= '0;
         flag         <= 1'b0;
         result       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         add_start    <= 1'b0;
         add_subtract <= 1'b0;
         add_in_a     <= '0;
         add_in_b     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_lat        <= in_a;
                  b_lat        <= in_b;
                  m_lat        <= in_m;
                  sub_lat      <= subtract;
                  busy         <= 1'b1;
                  // Outputs are registered, so the ISSUE1 values are loaded here.
                  add_start    <= 1'b1;
                  add_in_a     <= in_a;
                  add_in_b     <= in_b;
                  add_subtract <= subtract;
                  state        <= ISSUE1;
               end
            end
            ISSUE1: begin
               add_start <= 1'b0;
               state     <= WAIT1;
            end
            WAIT1: begin
               if (add_done) begin
                  s_reg        <= add_result[WIDTH-1:0];
                  flag         <= add_result[WIDTH];
                  add_start    <= 1'b1;
                  add_in_a     <= add_result[WIDTH-1:0];
                  add_in_b     <= m_lat;
                  add_subtract <= ~sub_lat;
                  state        <= ISSUE2;
               end
            end
            ISSUE2: begin
               add_start <= 1'b0;
               state     <= WAIT2;
            end
            WAIT2: begin
               if (add_done) begin
                  // add: S-M borrowed means S < M already; sub: a-b borrowed needs +M.
                  if (sub_lat == MP_SUB)
                     result <= flag ? add_result[WIDTH-1:0] : s_reg;
                  else
                     result <= add_result[WIDTH] ? s_reg : add_result[WIDTH-1:0];
                  done  <= 1'b1;
                  state <= FINISH;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // a_lat/b_lat document the accepted request; only M is reused after ISSUE1.
   logic unused_lat;
   assign unused_lat = ^{a_lat, b_lat};

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Directed bench for mod_addsub_ctrl with a behavioural fixed-latency mp adder.
module tb_mod_addsub_ctrl;

   localparam int W       = 1027;
   localparam int ADD_LAT = 3;
   localparam int LAT_EXP = 2 * ADD_LAT + 4;

   logic           clk = 1'b0;
   logic           resetn;
   logic           start;
   logic           subtract;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic [W-1:0]   in_m;
   logic           busy;
   logic [W-1:0]   result;
   logic           done;
   logic           add_start;
   logic           add_subtract;
   logic           add_carry_in;
   logic [W-1:0]   add_in_a;
   logic [W-1:0]   add_in_b;
   logic [W:0]     add_result;
   logic           add_done;

   int n_vec  = 0;
   int n_err  = 0;
   int n_starts = 0;
   int n_done   = 0;
   int stab_err = 0;

   always #5 clk = ~clk;

   mod_addsub_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .subtract     (subtract),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_m         (in_m),
      .busy         (busy),
      .result       (result),
      .done         (done),
      .add_start    (add_start),
      .add_subtract (add_subtract),
      .add_carry_in (add_carry_in),
      .add_in_a     (add_in_a),
      .add_in_b     (add_in_b),
      .add_result   (add_result),
      .add_done     (add_done)
   );

   // Adder model: add_done pulses ADD_LAT edges after the edge that samples add_start.
   logic [W:0] pend;
   int         cnt;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         add_done   <= 1'b0;
         add_result <= '0;
         pend       <= '0;
         cnt        <= 0;
      end else begin
         add_done <= 1'b0;
         if (add_start) begin
            cnt  <= ADD_LAT;
            pend <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                 : ({1'b0, add_in_a} + {1'b0, add_in_b});
         end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
               add_done   <= 1'b1;
               add_result <= pend;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (add_start) n_starts <= n_starts + 1;
      if (done)      n_done   <= n_done + 1;
   end

   // Adder operands must not move while an adder operation is outstanding.
   logic [W-1:0] snap_a, snap_b;
   logic         snap_s;
   always @(negedge clk) begin
      if (add_start) begin
         snap_a <= add_in_a;
         snap_b <= add_in_b;
         snap_s <= add_subtract;
      end else if (busy && (add_in_a !== snap_a || add_in_b !== snap_b || add_subtract !== snap_s)) begin
         stab_err <= stab_err + 1;
      end
   end

   task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] m, output logic [W-1:0] res,
                         output int lat, output int starts);
      int s0;
      s0 = n_starts;
      @(negedge clk);
      start = 1'b1; subtract = sub; in_a = a; in_b = b; in_m = m;
      @(negedge clk);
      start = 1'b0;
      in_a = {W{1'b1}}; in_b = {W{1'b1}}; in_m = {W{1'b1}};
      check("busy_after_accept", W'(busy), 1);
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      res    = result;
      starts = n_starts - s0;
      @(posedge clk); #1;
      check("done_one_cycle", W'(done), 0);
      check("busy_released", W'(busy), 0);
   endtask

   task automatic do_op(input string tag, input logic sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] m,
                        input logic [W-1:0] exp);
      logic [W-1:0] res;
      int lat, starts;
      run_op(sub, a, b, m, res, lat, starts);
      check({tag, "_result"}, {1'b0, res}, {1'b0, exp});
      check({tag, "_latency"}, W'(lat), W'(LAT_EXP));
      check({tag, "_add_starts"}, W'(starts), 2);
   endtask

   logic [W-1:0] big_m;
   logic [W-1:0] res5;
   int           s_base;
   int           d_base;
   int           lat5;

   initial begin
      resetn = 1'b0; start = 1'b0; subtract = 1'b0;
      in_a = '0; in_b = '0; in_m = '0;
      big_m = '0;
      big_m[1025] = 1'b1;
      big_m = big_m - 1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", W'(busy), 0);
      check("rst_done", W'(done), 0);
      check("rst_result", {1'b0, result}, 0);
      check("rst_add_start", W'(add_start), 0);
      check("rst_add_in_a", {1'b0, add_in_a}, 0);
      check("carry_in_zero", W'(add_carry_in), 0);
      @(negedge clk);
      resetn = 1'b1;

      do_op("add_wrap",   1'b0, W'(9), W'(7), W'(13), W'(3));
      do_op("add_nowrap", 1'b0, W'(5), W'(7), W'(13), W'(12));
      do_op("sub_borrow", 1'b1, W'(3), W'(7), W'(13), W'(9));
      do_op("sub_plain",  1'b1, W'(7), W'(3), W'(13), W'(4));
      do_op("big_add",    1'b0, big_m - 1, big_m - 1, big_m, big_m - 2);
      do_op("big_sub",    1'b1, W'(0), big_m - 1, big_m, W'(1));
      do_op("zero_add",   1'b0, W'(0), W'(0), big_m, W'(0));
      do_op("zero_sub",   1'b1, W'(0), W'(0), big_m, W'(0));

      // Second start during WAIT1 with different operands must be ignored.
      s_base = n_starts;
      @(negedge clk);
      start = 1'b1; subtract = 1'b0; in_a = W'(9); in_b = W'(7); in_m = W'(13);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; subtract = 1'b1; in_a = W'(1); in_b = W'(2); in_m = W'(5);
      @(negedge clk);
      start = 1'b0;
      lat5 = -1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat5 = i;
            break;
         end
      end
      check("busy_start_done_seen", W'(lat5 >= 0), 1);
      res5 = result;
      check("busy_start_result", {1'b0, res5}, W'(3));
      check("busy_start_add_starts", W'(n_starts - s_base), 2);
      repeat (5) @(posedge clk);
      #1;
      check("busy_start_not_queued", W'(busy), 0);
      check("operands_stable", W'(stab_err), 0);

      // Reset during WAIT2 aborts without a done pulse.
      s_base = n_starts;
      @(negedge clk);
      start = 1'b1; subtract = 1'b0; in_a = W'(9); in_b = W'(7); in_m = W'(13);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (n_starts - s_base >= 2) break;
      end
      check("rst_mid_reached_wait2", W'(n_starts - s_base), 2);
      @(posedge clk);
      @(negedge clk);
      d_base = n_done;
      resetn = 1'b0;
      #1;
      check("rst_mid_busy", W'(busy), 0);
      check("rst_mid_done", W'(done), 0);
      check("rst_mid_result", {1'b0, result}, 0);
      repeat (2 * ADD_LAT + 4) @(posedge clk);
      #1;
      check("rst_mid_no_done", W'(n_done - d_base), 0);
      @(negedge clk);
      resetn = 1'b1;
      do_op("after_reset", 1'b1, W'(3), W'(7), W'(13), W'(9));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench watchdog expired");
   end

endmodule
